// File: rtl/cursor_ctrl.sv
// Cursor controller: synchronised, debounced pushbuttons move a wrapping (x,y) cursor and emit flag/open pulses.
// Optional hold-to-repeat on the direction buttons is built when CURSOR_REPEAT_EN is defined.
module cursor_ctrl #(
   parameter int X_SIZE          = 16,
   parameter int Y_SIZE          = 16,
   parameter int X_BITS          = 4,
   parameter int Y_BITS          = 4,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int REPEAT_DELAY    = 8388608,
   parameter int REPEAT_RATE     = 2097152
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_left,
   input  logic              btn_right,
   input  logic              btn_flag,
   input  logic              btn_open,
   input  logic              busy,
   output logic [X_BITS-1:0] x_coord,
   output logic [Y_BITS-1:0] y_coord,
   output logic              flag,
   output logic              open
);

   localparam int NB = 6;
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_SIZE - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_SIZE - 1);

   // bit order: 0 up, 1 down, 2 left, 3 right, 4 flag, 5 open
   logic [NB-1:0]   raw;
   logic [NB-1:0]   sync1;
   logic [NB-1:0]   sync2;
   logic [NB-1:0]   deb;
   logic [NB-1:0]   deb_q;
   logic [NB-1:0]   press;
   logic [DB_W-1:0] db_cnt [NB];
   logic [3:0]      move_ev;
   logic            ev_up, ev_down, ev_left, ev_right;
   logic            act_ok;

   assign raw = {btn_open, btn_flag, btn_right, btn_left, btn_down, btn_up};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounced level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
      end else begin
         deb_q <= deb;
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i] <= '0;
               deb[i]    <= sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press = deb & ~deb_q;

`ifdef CURSOR_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RP_W = $clog2(RP_MAX + 1);
   localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_RATE - 1);

   logic [RP_W-1:0] rp_cnt [4];
   logic [3:0]      rep;

   // Down-counter per direction: loaded on press, fires at zero while still held, then reloads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) rp_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (press[i])
               rp_cnt[i] <= RP_FIRST;
            else if (deb[i] && deb_q[i])
               rp_cnt[i] <= (rp_cnt[i] == '0) ? RP_NEXT : rp_cnt[i] - 1'b1;
            else
               rp_cnt[i] <= '0;
         end
      end
   end

   always_comb begin
      rep = '0;
      for (int i = 0; i < 4; i++)
         rep[i] = deb[i] & deb_q[i] & (rp_cnt[i] == '0);
   end

   assign move_ev = press[3:0] | rep;
`else
   assign move_ev = press[3:0];
`endif

   assign ev_up    = move_ev[0];
   assign ev_down  = move_ev[1];
   assign ev_left  = move_ev[2];
   assign ev_right = move_ev[3];

   // Any move event, even a cancelled opposite pair, suppresses actions.
   assign act_ok = ~busy & ~(|move_ev);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_coord <= '0;
         y_coord <= '0;
         flag    <= 1'b0;
         open    <= 1'b0;
      end else begin
         if (ev_left && !ev_right)
            x_coord <= (x_coord == '0) ? X_LAST : x_coord - 1'b1;
         else if (ev_right && !ev_left)
            x_coord <= (x_coord == X_LAST) ? '0 : x_coord + 1'b1;

         if (ev_up && !ev_down)
            y_coord <= (y_coord == '0) ? Y_LAST : y_coord - 1'b1;
         else if (ev_down && !ev_up)
            y_coord <= (y_coord == Y_LAST) ? '0 : y_coord + 1'b1;

         flag <= press[4] & ~press[5] & act_ok;
         open <= press[5] & ~press[4] & act_ok;
      end
   end

endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 SHALL have parameter X_SIZE, default 16, board width in cells.
REQ-002 SHALL have parameter Y_SIZE, default 16, board height in cells.
REQ-003 SHALL have parameter X_BITS, default 4, x coordinate width; 2^X_BITS >= X_SIZE.
REQ-004 SHALL have parameter Y_BITS, default 4, y coordinate width; 2^Y_BITS >= Y_SIZE.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 65536, consecutive stable cycles before a debounced level changes; minimum 1.
REQ-006 SHALL have parameter REPEAT_DELAY, default 8388608, cycles held before the first auto-repeat.
REQ-007 SHALL have parameter REPEAT_RATE, default 2097152, cycles between subsequent auto-repeats.
REQ-008 SHALL have port clk  input  1  clock; all state on its rising edge.
REQ-009 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-010 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_flag, btn_open  input  1 each  raw asynchronous pushbuttons, active-high.
REQ-011 SHALL have port busy  input  1  downstream board-state store is initialising; actions not accepted.
REQ-012 SHALL have port x_coord  output  X_BITS  registered cursor column.
REQ-013 SHALL have port y_coord  output  Y_BITS  registered cursor row.
REQ-014 SHALL have ports flag, open  output  1 each  registered single-cycle action pulses.

Function
REQ-015 SHALL pass each button through a two-flop synchroniser before any other logic.
REQ-016 SHALL debounce each synchronised button independently: debounced level takes the synchronised value only after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement clears the counter.
REQ-017 SHALL generate a press event on each 0->1 transition of a debounced level; releases generate no event.
REQ-018 SHALL place a move or action output change exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples a stable raw press.
REQ-019 SHALL, on an up event, decrement y_coord, wrapping from 0 to Y_SIZE-1; on down, increment, wrapping from Y_SIZE-1 to 0.
REQ-020 SHALL, on a left event, decrement x_coord, wrapping from 0 to X_SIZE-1; on right, increment, wrapping from X_SIZE-1 to 0.
REQ-021 SHALL ignore both events in a cycle with up and down events together, or with left and right events together; x and y moves in the same cycle both apply.
REQ-022 SHALL assert flag, or open, for exactly one cycle per accepted flag or open event; the pulse coincides with the unchanged x_coord/y_coord it targets.
REQ-023 SHALL drop, not queue, a flag or open event in a cycle where busy=1, where flag and open events coincide, or where any move event occurs.
REQ-024 SHALL never assert flag and open in the same cycle.
REQ-025 SHALL hold x_coord/y_coord unchanged when no move event occurs, busy included.

Reset
REQ-026 SHALL, on reset assertion, immediately force x_coord=0, y_coord=0, flag=0, open=0, all synchroniser flops, debounced levels, debounce and repeat counters to 0.
REQ-027 SHALL discard any in-progress debounce or repeat count on reset; a button held through reset release produces one press event DEBOUNCE_CYCLES+3 edges after release.

Configuration
REQ-028 SHALL, with macro CURSOR_REPEAT_EN defined, generate an extra move event for a direction button held debounced-high REPEAT_DELAY cycles after its press event, then every REPEAT_RATE cycles while held; release stops repetition; simultaneous-opposite rules of REQ-021 apply to repeat events.
REQ-029 SHALL, with CURSOR_REPEAT_EN undefined, generate exactly one move event per press and contain no repeat counters.

Verification (bench: X_SIZE=Y_SIZE=16, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-030 SHALL cover: reset, btn_right held 30 cycles -> x_coord 0->1 exactly 7 edges after first sample, no further change, flag=open=0 throughout.
REQ-031 SHALL cover: btn_up toggling every cycle for 40 cycles -> no y_coord change; then clean press -> y_coord 0->15 (wrap).
REQ-032 SHALL cover: cursor at (15,3), press right -> (0,3); press open with busy=0 -> open high one cycle with x_coord=0, y_coord=3.
REQ-033 SHALL cover: busy=1 while pressing flag -> no flag pulse; flag and open pressed together with busy=0 -> neither pulse.
REQ-034 SHALL cover: CURSOR_REPEAT_EN defined, btn_down held 40 cycles from y=0 -> y_coord 1 on first event, 2 twenty cycles later, 3 after five more, 4 after five more; undefined -> y_coord stays 1.
REQ-035 SHALL cover: reset asserted mid-debounce of btn_left and with cursor at (7,9) -> outputs (0,0) and pulses 0 immediately, no left move from the aborted press.
